// File: rtl/bpsk_defs.sv
// Shared definitions for the BPSK receive bit slicer: default sizes,
// a ceil-log2 helper, the derived accumulator width and the action
// codes used by the output byte register.
package bpsk_defs;

  // Default samples per symbol (power of two, at least 2).
  localparam int DEF_SAMPLE_NUMBER = 256;

  // Default width of the signed demodulator sample.
  localparam int DEF_DATA_WIDTH = 12;

  // Default number of decided bits packed into one output word.
  localparam int DEF_BYTE_WIDTH = 8;

  // Ceil(log2(value)); returns 0 for value <= 1.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < value) begin
        result = i + 1;
      end
    end
    return result;
  endfunction

  // Accumulator width: a full symbol of extreme samples always fits,
  // so the integrator never needs saturation.
  localparam int DEF_ACC_W = DEF_DATA_WIDTH + clog2(DEF_SAMPLE_NUMBER);

  // What the output byte register does on a given cycle.
  typedef enum logic [1:0] {
    OUT_HOLD    = 2'd0,
    OUT_LOAD    = 2'd1,
    OUT_DROP    = 2'd2,
    OUT_CONSUME = 2'd3
  } out_action_e;

endpackage

// File: rtl/bpsk_bit_slicer_if.sv
// Sample input and byte output bundle of the BPSK bit slicer.
// The master side is the slicer itself; the slave side is whoever
// feeds samples and consumes bytes.
interface bpsk_bit_slicer_if
  import bpsk_defs::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int BYTE_WIDTH = DEF_BYTE_WIDTH
) ();

  logic                         en;
  logic signed [DATA_WIDTH-1:0] sample_in;
  logic                         bit_out;
  logic                         bit_valid;
  logic [BYTE_WIDTH-1:0]        data_out;
  logic                         data_valid;
  logic                         data_ready;
  logic                         overrun;

  modport master (
    input  en,
    input  sample_in,
    input  data_ready,
    output bit_out,
    output bit_valid,
    output data_out,
    output data_valid,
    output overrun
  );

  modport slave (
    output en,
    output sample_in,
    output data_ready,
    input  bit_out,
    input  bit_valid,
    input  data_out,
    input  data_valid,
    input  overrun
  );

endinterface

// File: rtl/bpsk_integrate_dump.sv
// Integrate-and-dump over one symbol of SAMPLE_NUMBER enabled samples,
// followed by a hard sign decision. The decision is presented
// combinationally in the cycle of the last sample so the parent can
// register the bit and pack it on the same edge.
module bpsk_integrate_dump
  import bpsk_defs::*;
#(
  parameter int SAMPLE_NUMBER = DEF_SAMPLE_NUMBER,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         en,
  input  logic signed [DATA_WIDTH-1:0] sample_in,
  output logic                         decision_bit,
  output logic                         decision_valid
);

  localparam int CNT_W = clog2(SAMPLE_NUMBER);
  localparam int ACC_W = DATA_WIDTH + CNT_W;
  localparam int EXT_W = ACC_W - DATA_WIDTH;

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] sum_next;
  logic [CNT_W-1:0]        sample_cnt_q;
  logic                    last_sample;

  assign sample_ext  = {{EXT_W{sample_in[DATA_WIDTH-1]}}, sample_in};
  assign sum_next    = acc_q + sample_ext;
  assign last_sample = (sample_cnt_q == CNT_W'(SAMPLE_NUMBER - 1));

  // An exact zero sum is a 0 decision, so only strictly positive sums give 1.
  assign decision_bit   = ~sum_next[ACC_W-1] & (|sum_next);
  assign decision_valid = en & last_sample;

  // Accumulate enabled samples; dump to zero and wrap the count at symbol end.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q        <= '0;
      sample_cnt_q <= '0;
    end else if (en) begin
      if (last_sample) begin
        acc_q        <= '0;
        sample_cnt_q <= '0;
      end else begin
        acc_q        <= sum_next;
        sample_cnt_q <= sample_cnt_q + CNT_W'(1);
      end
    end
  end

endmodule

// File: rtl/bpsk_bit_slicer.sv
// BPSK bit slicer: integrates demodulated samples per symbol, decides
// each bit on the sign of the sum, packs bits MSB-first into words and
// offers each word on a valid/ready output with sticky overrun.
module bpsk_bit_slicer
  import bpsk_defs::*;
#(
  parameter int SAMPLE_NUMBER = DEF_SAMPLE_NUMBER,
  parameter int DATA_WIDTH    = DEF_DATA_WIDTH,
  parameter int BYTE_WIDTH    = DEF_BYTE_WIDTH
) (
  input  logic              clk,
  input  logic              rst,
  bpsk_bit_slicer_if.master bus
);

  localparam int BIT_CNT_W = (clog2(BYTE_WIDTH) < 1) ? 1 : clog2(BYTE_WIDTH);

  logic                  dec_bit;
  logic                  dec_valid;
  logic                  bit_out_q;
  logic                  bit_valid_q;
  logic [BYTE_WIDTH-1:0] shift_q;
  logic [BYTE_WIDTH-1:0] next_shift;
  logic [BIT_CNT_W-1:0]  bit_cnt_q;
  logic                  byte_done;
  logic [BYTE_WIDTH-1:0] data_out_q;
  logic                  data_valid_q;
  logic                  overrun_q;
  out_action_e           out_action;

  bpsk_integrate_dump #(
    .SAMPLE_NUMBER (SAMPLE_NUMBER),
    .DATA_WIDTH    (DATA_WIDTH)
  ) u_integrate_dump (
    .clk            (clk),
    .rst            (rst),
    .en             (bus.en),
    .sample_in      (bus.sample_in),
    .decision_bit   (dec_bit),
    .decision_valid (dec_valid)
  );

  // The word including the bit being decided right now; it is what gets
  // offered to the output register when this decision completes a word.
  assign next_shift = (shift_q << 1) | BYTE_WIDTH'(dec_bit);
  assign byte_done  = dec_valid & (bit_cnt_q == BIT_CNT_W'(BYTE_WIDTH - 1));

  // Register each decision as a one-cycle bit strobe; bit_out keeps the last bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_out_q   <= 1'b0;
      bit_valid_q <= 1'b0;
    end else begin
      bit_valid_q <= dec_valid;
      if (dec_valid) begin
        bit_out_q <= dec_bit;
      end
    end
  end

  // Shift decided bits in at the LSB and count positions within the word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      shift_q   <= '0;
      bit_cnt_q <= '0;
    end else if (dec_valid) begin
      shift_q <= next_shift;
      if (byte_done) begin
        bit_cnt_q <= '0;
      end else begin
        bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
      end
    end
  end

  // Pick the output register action; a load beats a consume, and a load
  // into a full register that is not being drained drops the new word.
  always_comb begin
    out_action = OUT_HOLD;
    if (byte_done) begin
      if (!data_valid_q || bus.data_ready) begin
        out_action = OUT_LOAD;
      end else begin
        out_action = OUT_DROP;
      end
    end else if (data_valid_q && bus.data_ready) begin
      out_action = OUT_CONSUME;
    end
  end

  // Output word register with sticky overrun; data_out is kept after consume.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      data_out_q   <= '0;
      data_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      case (out_action)
        OUT_LOAD: begin
          data_out_q   <= next_shift;
          data_valid_q <= 1'b1;
        end
        OUT_DROP: begin
          overrun_q <= 1'b1;
        end
        OUT_CONSUME: begin
          data_valid_q <= 1'b0;
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.bit_out    = bit_out_q;
  assign bus.bit_valid  = bit_valid_q;
  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;
  assign bus.overrun    = overrun_q;

endmodule

// File: tb/tb_bpsk_bit_slicer.sv
// Directed self-checking bench for bpsk_bit_slicer. A small instance
// (4 samples per symbol) covers decisions, packing and the output
// handshake; a default-sized instance covers full-scale integration.
module tb_bpsk_bit_slicer;
  import bpsk_defs::*;

  localparam int SN = 4;
  localparam int DW = 12;
  localparam int BW = 8;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  bpsk_bit_slicer_if #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW)) bus ();
  bpsk_bit_slicer_if bus_big ();

  bpsk_bit_slicer #(
    .SAMPLE_NUMBER (SN),
    .DATA_WIDTH    (DW),
    .BYTE_WIDTH    (BW)
  ) u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  bpsk_bit_slicer u_big (
    .clk (clk),
    .rst (rst),
    .bus (bus_big.master)
  );

  // Free-running 10 ns clock.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Drive one cycle of the small instance; returns 1 ns after the edge.
  task automatic applyStimulus(input logic en, input int sample);
    bus.en        = en;
    bus.sample_in = DW'(sample);
    @(posedge clk);
    #1;
  endtask

  // One symbol of SN samples of +/-amp; optionally assert data_ready only
  // during the final sample cycle.
  task automatic sendSymbol(input logic b, input int amp, input logic ready_last);
    logic saved_ready;
    saved_ready = bus.data_ready;
    for (int i = 0; i < SN; i++) begin
      if (i == SN - 1 && ready_last) bus.data_ready = 1'b1;
      applyStimulus(1'b1, b ? amp : -amp);
    end
    bus.data_ready = saved_ready;
  endtask

  task automatic sendByte(input logic [7:0] value, input logic ready_last);
    for (int i = 7; i >= 0; i--) begin
      sendSymbol(value[i], 300, (i == 0) && ready_last);
    end
  endtask

  task automatic doReset();
    bus.en         = 1'b0;
    bus.data_ready = 1'b0;
    #2 rst = 1'b0;
    #3 rst = 1'b1;
  endtask

  initial begin
    logic [7:0] pat;
    checks   = 0;
    failures = 0;
    rst      = 1'b0;
    bus.en = 1'b0; bus.sample_in = '0; bus.data_ready = 1'b0;
    bus_big.en = 1'b0; bus_big.sample_in = '0; bus_big.data_ready = 1'b0;

    #12;
    checkOutput("reset bit_out", bus.bit_out, 0);
    checkOutput("reset bit_valid", bus.bit_valid, 0);
    checkOutput("reset data_out", bus.data_out, 0);
    checkOutput("reset data_valid", bus.data_valid, 0);
    checkOutput("reset overrun", bus.overrun, 0);
    checkOutput("reset big bit_valid", bus_big.bit_valid, 0);
    rst = 1'b1;

    // Single positive symbol: sum 400 decides 1 one cycle after the 4th sample.
    for (int i = 0; i < SN; i++) begin
      applyStimulus(1'b1, 100);
      if (i == SN - 2) checkOutput("no early decision", bus.bit_valid, 0);
    end
    checkOutput("pos symbol bit_valid", bus.bit_valid, 1);
    checkOutput("pos symbol bit_out", bus.bit_out, 1);
    applyStimulus(1'b0, 0);
    checkOutput("bit_valid one cycle", bus.bit_valid, 0);
    checkOutput("bit_out held", bus.bit_out, 1);

    // Byte 0xA5 packed MSB-first, then consumed.
    doReset();
    pat = 8'hA5;
    for (int i = 7; i >= 0; i--) begin
      sendSymbol(pat[i], 300, 1'b0);
      if (i == 1) checkOutput("no byte after 7 bits", bus.data_valid, 0);
    end
    checkOutput("A5 data_valid", bus.data_valid, 1);
    checkOutput("A5 data_out", bus.data_out, 8'hA5);
    checkOutput("A5 last bit_valid", bus.bit_valid, 1);
    checkOutput("A5 last bit_out", bus.bit_out, 1);
    bus.data_ready = 1'b1;
    applyStimulus(1'b0, 0);
    bus.data_ready = 1'b0;
    checkOutput("consume data_valid", bus.data_valid, 0);
    checkOutput("consume overrun", bus.overrun, 0);
    checkOutput("data_out kept", bus.data_out, 8'hA5);

    // Decision boundaries: zero sum, minimal positive, full-scale symbols.
    doReset();
    applyStimulus(1'b1, 5);  applyStimulus(1'b1, -5);
    applyStimulus(1'b1, 3);  applyStimulus(1'b1, -3);
    checkOutput("zero sum bit_valid", bus.bit_valid, 1);
    checkOutput("zero sum bit_out", bus.bit_out, 0);
    applyStimulus(1'b1, -1); applyStimulus(1'b1, 0);
    applyStimulus(1'b1, 0);  applyStimulus(1'b1, 2);
    checkOutput("sum +1 bit_out", bus.bit_out, 1);
    for (int i = 0; i < SN; i++) applyStimulus(1'b1, -2048);
    checkOutput("min samples bit_out", bus.bit_out, 0);
    for (int i = 0; i < SN; i++) applyStimulus(1'b1, 2047);
    checkOutput("max samples bit_out", bus.bit_out, 1);

    // Overrun: second byte arrives while first is unconsumed.
    doReset();
    sendByte(8'hA5, 1'b0);
    checkOutput("first byte valid", bus.data_valid, 1);
    checkOutput("first byte no overrun", bus.overrun, 0);
    sendByte(8'h3C, 1'b0);
    checkOutput("dropped keeps old", bus.data_out, 8'hA5);
    checkOutput("overrun set", bus.overrun, 1);
    checkOutput("still valid", bus.data_valid, 1);
    bus.data_ready = 1'b1;
    applyStimulus(1'b0, 0);
    checkOutput("drain data_valid", bus.data_valid, 0);
    checkOutput("overrun sticky", bus.overrun, 1);
    applyStimulus(1'b0, 0);
    bus.data_ready = 1'b0;
    checkOutput("ready idle no effect", bus.data_valid, 0);

    // Load coincides with consume of the previous byte.
    doReset();
    sendByte(8'hA5, 1'b0);
    sendByte(8'h3C, 1'b1);
    checkOutput("swap data_out", bus.data_out, 8'h3C);
    checkOutput("swap data_valid", bus.data_valid, 1);
    checkOutput("swap overrun", bus.overrun, 0);
    applyStimulus(1'b0, 0);
    checkOutput("swap held", bus.data_valid, 1);

    // Enable gap mid-symbol: disabled samples must be ignored.
    doReset();
    applyStimulus(1'b1, 50);
    applyStimulus(1'b1, 50);
    for (int i = 0; i < 10; i++) applyStimulus(1'b0, -2000);
    checkOutput("gap no decision", bus.bit_valid, 0);
    applyStimulus(1'b1, -10);
    checkOutput("3rd sample no decision", bus.bit_valid, 0);
    applyStimulus(1'b1, -10);
    checkOutput("gap bit_valid", bus.bit_valid, 1);
    checkOutput("gap bit_out", bus.bit_out, 1);

    // Reset after 3 bits and a partial symbol; next byte packs from bit 0.
    doReset();
    sendSymbol(1'b1, 300, 1'b0);
    sendSymbol(1'b1, 300, 1'b0);
    sendSymbol(1'b1, 300, 1'b0);
    applyStimulus(1'b1, 2000);
    applyStimulus(1'b1, 2000);
    bus.en = 1'b0;
    #2 rst = 1'b0;
    #1;
    checkOutput("async reset bit_out", bus.bit_out, 0);
    checkOutput("async reset bit_valid", bus.bit_valid, 0);
    checkOutput("async reset data_valid", bus.data_valid, 0);
    #2 rst = 1'b1;
    sendByte(8'h3C, 1'b0);
    checkOutput("post reset data_valid", bus.data_valid, 1);
    checkOutput("post reset data_out", bus.data_out, 8'h3C);
    checkOutput("post reset overrun", bus.overrun, 0);

    // Default-sized instance: 256 full-scale samples per symbol.
    for (int i = 0; i < 256; i++) begin
      bus_big.en        = 1'b1;
      bus_big.sample_in = 12'h800;
      @(posedge clk);
      #1;
      if (i == 254) checkOutput("big no early decision", bus_big.bit_valid, 0);
    end
    checkOutput("big min bit_valid", bus_big.bit_valid, 1);
    checkOutput("big min bit_out", bus_big.bit_out, 0);
    for (int i = 0; i < 256; i++) begin
      bus_big.sample_in = 12'h7FF;
      @(posedge clk);
      #1;
    end
    checkOutput("big max bit_out", bus_big.bit_out, 1);
    bus_big.en = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("big bit_valid drop", bus_big.bit_valid, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule

// File: doc/bpsk_bit_slicer.md
Name: bpsk_bit_slicer

Overview:
Downstream neighbour of bpsk_demodulator. Consumes the demodulator's per-sample output `q`. For each symbol it integrates over SAMPLE_NUMBER samples and dumps the sum (integrate-and-dump), then makes a hard bit decision on the sign of the sum. Decided bits are packed MSB-first into bytes. Each byte is presented on a valid/ready output with sticky overrun detection. Feeds the receive byte path (framer/UART side).

Parameters:
SAMPLE_NUMBER, 256, samples per symbol; power of two, ≥2.
DATA_WIDTH, 12, width of signed two's-complement input sample.
BYTE_WIDTH, 8, bits per output word.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-low reset.
en  input  1  sample strobe; one input sample consumed per cycle while high.
sample_in  input  DATA_WIDTH  signed demodulated sample (demodulator `q`).
bit_out  output  1  last decided bit.
bit_valid  output  1  one-cycle pulse per decided bit.
data_out  output  BYTE_WIDTH  packed byte, first received bit in MSB.
data_valid  output  1  data_out holds an unconsumed byte.
data_ready  input  1  consumer accepts data_out when data_valid & data_ready at a rising edge.
overrun  output  1  sticky: a completed byte was dropped.

Behaviour:
- Reset (rst low, asynchronous) clears every register: accumulator, sample_cnt, bit_cnt, shift register, bit_out, bit_valid, data_out, data_valid and overrun are all 0.
  - Reset mid-symbol discards the partial sum and any partial byte.
  - After release, counting restarts at sample 0.
- Accumulator width ACC_W = DATA_WIDTH + log2(SAMPLE_NUMBER), which is 20 by default.
  - Inputs are sign-extended; no saturation is needed because the range is provably sufficient.
- While en=1 on a cycle:
  - sum_next = acc + sample_in; sample_cnt increments.
  - When sample_cnt == SAMPLE_NUMBER-1:
    - bit = (sum_next > 0) ? 1 : 0. An exact zero decides 0.
    - acc is cleared to 0 and sample_cnt wraps to 0.
    - bit_out := bit and bit_valid := 1 on the next edge, giving latency 1 cycle after the last sample of the symbol.
  - Otherwise acc := sum_next.
- While en=0: acc, sample_cnt, bit_cnt and the shift register hold, and bit_valid = 0. The output handshake keeps operating.
- Byte packing:
  - On each decision the shift register shifts left with bit inserted at the LSB, and bit_cnt increments.
  - When the decision is the BYTE_WIDTH-th bit, bit_cnt wraps to 0 and the completed byte is offered to the output register in that same cycle.
  - data_valid therefore rises on the same edge as the final bit_valid.
- Output register:
  - data_out and data_valid change only on a load, or on a consume (data_valid & data_ready), which clears data_valid.
  - data_out is not cleared on consume.
  - Load with the register empty, or simultaneous with a consume: the new byte is loaded and data_valid = 1. No overrun.
  - Load while data_valid=1 and data_ready=0: the new byte is dropped, the old byte is kept, and overrun := 1.
  - overrun clears only on reset.
- data_ready while data_valid=0 has no effect.

Decomposition:
- Shared package/include bpsk_defs holds:
  - the default SAMPLE_NUMBER, DATA_WIDTH and BYTE_WIDTH;
  - a clog2 function;
  - the derived ACC_W.
- One natural sub-module, bpsk_integrate_dump, contains the accumulator, sample counter and sign decision. Its outputs are bit and bit_valid.
- The top level contains the packer and the output register.

Test Plan:
- SAMPLE_NUMBER=4. rst low, then high, en=1, sample_in=+100 for 4 cycles → bit_valid pulses one cycle after the 4th sample with bit_out=1. Internal sum 400; acc returns to 0.
- Eight symbols, each 4 samples of ±300 (sign per bit) following bits 1,0,1,0,0,1,0,1 → data_out=8'hA5 and data_valid=1 on the edge of the 8th bit_valid. With data_ready=1 one cycle later, data_valid drops and overrun stays 0.
- Symbol samples +5, -5, +3, -3 (sum 0) → bit_out=0. Samples -2048 ×4 → bit_out=0; samples +2047 ×4 → bit_out=1 with no wrap. At default parameters, 256 × -2048 → bit_out=0 with no overflow.
- data_ready held 0 while two full bytes (0xA5 then 0x3C) are received → data_out stays 0xA5, overrun=1 after the second byte. Then data_ready=1 → data_valid=0, overrun stays 1.
- Byte completes on the same cycle data_ready=1 consumes the prior byte → new byte loaded, data_valid stays 1, overrun=0.
- en dropped for 10 cycles after sample 2 of a symbol, then resumed → the decision occurs after 4 total enabled samples and is unaffected by the gap. rst pulsed low after 3 bits of a byte → all outputs 0; the next byte packs from bit 0.
